// File: rtl/cordic_sincos_pipe.sv
// cordic_sincos_pipe: fully pipelined rotation-mode CORDIC producing cos/sin
// of a full-circle binary angle with valid/ready flow control and a
// pass-through tag. One fold stage, N iteration stages, one output stage.
// Optional build macro CORDIC_ROUND_SAT_EN: round-half-up by GUARD bits and
// saturate on the output; otherwise the GUARD LSBs are truncated.
module cordic_sincos_pipe #(
   parameter int XY_W  = 18,
   parameter int Z_W   = 16,
   parameter int N     = 16,
   parameter int GUARD = 3,
   parameter int TAG_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [Z_W-1:0]          in_angle,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [XY_W-1:0]  out_cos,
   output logic signed [XY_W-1:0]  out_sin,
   output logic [TAG_W-1:0]        out_tag
);

   // Internal x/y carry GUARD extra LSBs plus one headroom bit
   localparam int XW = XY_W + GUARD + 1;

   // Start vector pre-scaled by the CORDIC gain so the result lands on 1.0
   localparam logic signed [XW-1:0] XINIT =
      XW'($rtoi(0.6072529350 * (2.0 ** (XY_W - 2 + GUARD)) + 0.5));

`ifdef CORDIC_ROUND_SAT_EN
   localparam int RND = (GUARD > 0) ? (1 << (GUARD - 1)) : 0;
   localparam logic signed [XY_W+1:0] QMAX = (XY_W+2)'((2 ** (XY_W - 1)) - 1);
   localparam logic signed [XY_W+1:0] QMIN = (XY_W+2)'(-(2 ** (XY_W - 1)));
`endif

   // atan(2^-i) in units of 2^-32 turn
   function automatic logic [31:0] atanTurns(input int i);
      case (i)
         0:  return 32'h20000000;
         1:  return 32'h12E4051E;
         2:  return 32'h09FB385B;
         3:  return 32'h051111D4;
         4:  return 32'h028B0D43;
         5:  return 32'h0145D7E1;
         6:  return 32'h00A2F61E;
         7:  return 32'h00517C55;
         8:  return 32'h0028BE53;
         9:  return 32'h00145F2F;
         10: return 32'h000A2F98;
         11: return 32'h000517CC;
         12: return 32'h00028BE6;
         13: return 32'h000145F3;
         14: return 32'h0000A2FA;
         15: return 32'h0000517D;
         16: return 32'h000028BE;
         17: return 32'h0000145F;
         18: return 32'h00000A30;
         19: return 32'h00000518;
         20: return 32'h0000028C;
         21: return 32'h00000146;
         22: return 32'h000000A3;
         23: return 32'h00000051;
         default: return 32'h00000000;
      endcase
   endfunction

   // Angle step rescaled to Z_W bits with round-half-up
   function automatic logic signed [Z_W-1:0] atanStep(input int i);
      logic [31:0] t;
      t = atanTurns(i) + (32'd1 << (31 - Z_W));
      return t[32-Z_W +: Z_W];
   endfunction

   // Drop the guard bits of one output component
   function automatic logic signed [XY_W-1:0] shapeOut(input logic signed [XW-1:0] v);
`ifdef CORDIC_ROUND_SAT_EN
      logic signed [XW:0]     r;
      logic signed [XY_W+1:0] q;
      r = {v[XW-1], v} + (XW+1)'(RND);
      q = (XY_W+2)'(r >>> GUARD);
      if (q > QMAX)
         return {1'b0, {(XY_W-1){1'b1}}};
      else if (q < QMIN)
         return {1'b1, {(XY_W-1){1'b0}}};
      else
         return q[XY_W-1:0];
`else
      return v[GUARD +: XY_W];
`endif
   endfunction

   logic                   advance;
   logic [N:0]             vld;
   logic [N:0]             flips;
   logic signed [XW-1:0]   xs [0:N];
   logic signed [XW-1:0]   ys [0:N];
   logic signed [Z_W-1:0]  zs [0:N];
   logic [TAG_W-1:0]       tags [0:N];
   logic signed [XW-1:0]   xn [0:N-1];
   logic signed [XW-1:0]   yn [0:N-1];
   logic signed [Z_W-1:0]  zn [0:N-1];
   logic signed [XW-1:0]   xsh, ysh;
   logic [1:0]             quad;
   logic                   foldFlip;
   logic [Z_W-1:0]         foldZ;
   logic signed [XW-1:0]   xf, yf;

   // Whole pipeline moves together; it stalls only when a result is held
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Fold quadrants 1 and 2 onto -90..+90 by subtracting 180 degrees
   always_comb begin
      quad     = in_angle[Z_W-1:Z_W-2];
      foldFlip = (quad == 2'b01) | (quad == 2'b10);
      foldZ    = {in_angle[Z_W-1] ^ foldFlip, in_angle[Z_W-2:0]};
   end

   // One micro-rotation per stage, direction chosen by the sign of residual z
   always_comb begin
      xsh = '0;
      ysh = '0;
      for (int i = 0; i < N; i++) begin
         xsh = xs[i] >>> i;
         ysh = ys[i] >>> i;
         if (!zs[i][Z_W-1]) begin
            xn[i] = xs[i] - ysh;
            yn[i] = ys[i] + xsh;
            zn[i] = zs[i] - atanStep(i);
         end else begin
            xn[i] = xs[i] + ysh;
            yn[i] = ys[i] - xsh;
            zn[i] = zs[i] + atanStep(i);
         end
      end
   end

   // Datapath registers need no reset: validity is tracked separately
   always_ff @(posedge clk) begin
      if (advance) begin
         xs[0]    <= XINIT;
         ys[0]    <= '0;
         zs[0]    <= foldZ;
         flips[0] <= foldFlip;
         tags[0]  <= in_tag;
         for (int i = 0; i < N; i++) begin
            xs[i+1]    <= xn[i];
            ys[i+1]    <= yn[i];
            zs[i+1]    <= zn[i];
            flips[i+1] <= flips[i];
            tags[i+1]  <= tags[i];
         end
      end
   end

   // Valid shift register; bubbles travel with the data
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vld <= '0;
      else if (advance)
         vld <= {vld[N-1:0], in_valid};
   end

   // Undo the 180-degree fold on the final vector
   always_comb begin
      xf = flips[N] ? -xs[N] : xs[N];
      yf = flips[N] ? -ys[N] : ys[N];
   end

   // Output register, cleared by reset so nothing stale is presented
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_cos   <= '0;
         out_sin   <= '0;
         out_tag   <= '0;
      end else if (advance) begin
         out_valid <= vld[N];
         out_cos   <= shapeOut(xf);
         out_sin   <= shapeOut(yf);
         out_tag   <= tags[N];
      end
   end

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// tb_cordic_sincos_pipe: self-checking bench for cordic_sincos_pipe using a
// real-valued rotation model and an in-order scoreboard of accepted samples.
module tb_cordic_sincos_pipe;

   localparam int XY_W  = 18;
   localparam int Z_W   = 16;
   localparam int N     = 16;
   localparam int GUARD = 3;
   localparam int TAG_W = 4;
   localparam int LAT   = N + 2;

   logic                   clk;
   logic                   reset;
   logic                   in_valid;
   logic                   in_ready;
   logic [Z_W-1:0]         in_angle;
   logic [TAG_W-1:0]       in_tag;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [XY_W-1:0] out_cos;
   logic signed [XY_W-1:0] out_sin;
   logic [TAG_W-1:0]       out_tag;

   typedef struct {
      int angle;
      int tag;
   } sample_t;

   sample_t expq[$];
   int      checks = 0;
   int      passes = 0;
   bit      accepted;
   bit      popped;
   bit      sawValid;

   cordic_sincos_pipe #(
      .XY_W(XY_W), .Z_W(Z_W), .N(N), .GUARD(GUARD), .TAG_W(TAG_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_angle(in_angle),
      .in_tag(in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_cos(out_cos),
      .out_sin(out_sin),
      .out_tag(out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint obs, input longint exp, input longint tol);
      checks++;
      if (obs > exp + tol || obs < exp - tol)
         $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)", name, obs, exp, tol);
      else
         passes++;
   endtask

   // Rotation actually performed: fold by 180 degrees, then a sequence of
   // +/-atan(2^-i) rotations whose signs follow the residual angle kept in
   // Z_W-bit units with a rounded angle table; magnitude is the prescale
   // times the accumulated CORDIC gain.
   function automatic void refModel(input int ang, output int c, output int s);
      real pi;
      real rot;
      real mag;
      real at;
      int  a2;
      int  z;
      int  aq;
      int  q;
      bit  flip;
      pi   = 3.14159265358979323846;
      q    = (ang >> (Z_W - 2)) & 3;
      flip = (q == 1) || (q == 2);
      a2   = flip ? (ang ^ (1 << (Z_W - 1))) : ang;
      z    = (a2 >= (1 << (Z_W - 1))) ? a2 - (1 << Z_W) : a2;
      rot  = 0.0;
      mag  = $floor(0.6072529350 * $pow(2.0, XY_W - 2 + GUARD) + 0.5) / $pow(2.0, GUARD);
      for (int i = 0; i < N; i++) begin
         at  = $atan($pow(2.0, -i));
         aq  = int'($floor(at / (2.0 * pi) * $pow(2.0, Z_W) + 0.5));
         mag = mag * $sqrt(1.0 + $pow(2.0, -2 * i));
         if (z >= 0) begin
            z   = z - aq;
            rot = rot + at;
         end else begin
            z   = z + aq;
            rot = rot - at;
         end
      end
      if (flip)
         rot = rot + pi;
      c = int'(mag * $cos(rot));
      s = int'(mag * $sin(rot));
   endfunction

   // One clock: observe handshakes at the falling edge, then step past the rising edge
   task automatic applyStimulus();
      sample_t e;
      int      c;
      int      s;
      real     nrm;
      @(negedge clk);
      checkOutput("in_ready", in_ready, (!out_valid) || out_ready, 0);
      sawValid = out_valid;
      popped   = 1'b0;
      accepted = 1'b0;
      if (out_valid && out_ready) begin
         popped = 1'b1;
         if (expq.size() == 0) begin
            checkOutput("unexpected_out", out_tag, -1, 0);
         end else begin
            e = expq.pop_front();
            refModel(e.angle, c, s);
            checkOutput("tag", out_tag, e.tag, 0);
            checkOutput("cos", out_cos, c, 8);
            checkOutput("sin", out_sin, s, 8);
            nrm = (real'(out_cos) * real'(out_cos) + real'(out_sin) * real'(out_sin))
                  / $pow(2.0, 2 * (XY_W - 2));
            checkOutput("norm_ppm", longint'(nrm * 1.0e6), 1000000, 1000);
         end
      end
      if (in_valid && in_ready) begin
         accepted = 1'b1;
         expq.push_back('{int'(in_angle), int'(in_tag)});
      end
      @(posedge clk);
      #1;
   endtask

   // Send one sample into an idle pipeline and measure its latency
   task automatic sendDirected(input int ang, input int tag);
      int lat;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_angle  = Z_W'(ang);
      in_tag    = TAG_W'(tag);
      applyStimulus();
      checkOutput("accept", accepted, 1, 0);
      in_valid = 1'b0;
      lat = 0;
      sawValid = 1'b0;
      while (!sawValid && lat < 100) begin
         applyStimulus();
         lat++;
      end
      checkOutput("latency", lat, LAT, 0);
   endtask

   initial begin
      int sent;
      int got;
      int calls;
      int first;
      int gaps;
      int stale;
      int nextTag;
      bit pend;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_angle  = '0;
      in_tag    = '0;
      #12;
      checkOutput("rst_valid", out_valid, 0, 0);
      checkOutput("rst_cos", out_cos, 0, 0);
      checkOutput("rst_sin", out_sin, 0, 0);
      checkOutput("rst_tag", out_tag, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus();

      // Directed quadrant boundaries and 45 degrees
      sendDirected(16'h0000, 3);
      sendDirected(16'h4000, 5);
      sendDirected(16'h8000, 6);
      sendDirected(16'hC000, 7);
      sendDirected(16'h2000, 8);
      checkOutput("directed_drained", expq.size(), 0, 0);

      // Continuous full-circle ramp at one sample per clock
      sent = 0; got = 0; calls = 0; first = 0; gaps = 0;
      out_ready = 1'b1;
      while ((sent < 1024 || expq.size() > 0) && calls < 1400) begin
         in_valid = (sent < 1024);
         in_angle = Z_W'(sent * 64);
         in_tag   = TAG_W'(sent);
         applyStimulus();
         calls++;
         if (accepted) sent++;
         if (popped) got++;
         if (sawValid && first == 0)
            first = calls;
         else if (first != 0 && !sawValid && got < 1024)
            gaps++;
      end
      in_valid = 1'b0;
      checkOutput("ramp_count", got, 1024, 0);
      checkOutput("ramp_first", first, LAT + 1, 0);
      checkOutput("ramp_gaps", gaps, 0, 0);

      // Random valid and backpressure; the source holds a pending sample
      pend = 1'b0;
      nextTag = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!pend && $urandom_range(1, 0) == 1) begin
            pend     = 1'b1;
            in_angle = Z_W'($urandom);
            in_tag   = TAG_W'(nextTag);
            nextTag++;
         end
         in_valid  = pend;
         out_ready = ($urandom_range(1, 0) == 1);
         applyStimulus();
         if (accepted) pend = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      calls = 0;
      while (expq.size() > 0 && calls < 200) begin
         applyStimulus();
         calls++;
      end
      checkOutput("random_drained", expq.size(), 0, 0);

      // Reset with a full pipeline in flight
      for (int k = 0; k < 25; k++) begin
         in_valid = 1'b1;
         in_angle = Z_W'(k * 1000);
         in_tag   = TAG_W'(k);
         applyStimulus();
      end
      checkOutput("pre_rst_valid", out_valid, 1, 0);
      reset = 1'b1;
      #1;
      checkOutput("rst_async_valid", out_valid, 0, 0);
      checkOutput("rst_async_cos", out_cos, 0, 0);
      expq.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      stale = 0;
      for (int k = 0; k < 30; k++) begin
         applyStimulus();
         if (sawValid) stale++;
      end
      checkOutput("stale_out", stale, 0, 0);
      sendDirected(16'h1234, 9);
      checkOutput("final_drained", expq.size(), 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
